// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - tempo-driven song player: reads (note, duration) ROM words and holds each note for its tick count
// Optional SEQ_GAP_EN: rest the last GAP_TICKS ticks of each eligible note; undefined gives legato playback.
module note_sequencer #(
  parameter int unsigned TICK_DIV  = 1562500,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned GAP_TICKS = 1
) (
  input  logic              CLK100MHZ,
  input  logic              rst,
  input  logic              play,
  input  logic              loop,
  input  logic [1:0]        tempo_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [7:0]        note,
  output logic              note_strobe,
  output logic              busy,
  output logic              done
);

`ifdef SEQ_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif
  localparam int PRE_W = $clog2(TICK_DIV + 1);
  localparam logic [7:0] GAP_L = 8'(GAP_TICKS);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_PLAY, S_PAUSE, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [7:0]        cur_note_q, cur_note_d;
  logic [7:0]        dur_q, dur_d;
  logic [7:0]        remaining_q, remaining_d;
  logic [7:0]        note_q, note_d;
  logic              note_strobe_q, note_strobe_d;
  logic [PRE_W-1:0]  prescaler_q, prescaler_d;
  logic [PRE_W-1:0]  period;
  logic              tick;

  // A shorter period taking effect mid-tick wraps at once instead of underflowing.
  assign period = PRE_W'(TICK_DIV >> tempo_sel);
  assign tick   = (prescaler_q >= period - PRE_W'(1));

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rom_addr_q    <= '0;
      cur_note_q    <= '0;
      dur_q         <= '0;
      remaining_q   <= '0;
      note_q        <= '0;
      note_strobe_q <= 1'b0;
      prescaler_q   <= '0;
    end else begin
      state_q       <= state_d;
      rom_addr_q    <= rom_addr_d;
      cur_note_q    <= cur_note_d;
      dur_q         <= dur_d;
      remaining_q   <= remaining_d;
      note_q        <= note_d;
      note_strobe_q <= note_strobe_d;
      prescaler_q   <= prescaler_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rom_addr_d    = rom_addr_q;
    cur_note_d    = cur_note_q;
    dur_d         = dur_q;
    remaining_d   = remaining_q;
    prescaler_d   = prescaler_q;
    note_strobe_d = 1'b0;
    note_d        = note_q;

    case (state_q)
      S_IDLE: begin
        if (play) begin
          rom_addr_d = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        if (rom_data[7:0] == 8'd0) begin
          if (loop) begin
            rom_addr_d = '0;
            state_d    = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cur_note_d    = rom_data[15:8];
          dur_d         = rom_data[7:0];
          remaining_d   = rom_data[7:0];
          prescaler_d   = '0;
          note_strobe_d = 1'b1;
          state_d       = play ? S_PLAY : S_PAUSE;
        end
      end
      S_PLAY: begin
        if (!play) state_d = S_PAUSE;
        if (tick) begin
          prescaler_d = '0;
          remaining_d = remaining_q - 8'd1;
          // The last tick advances even when play drops on the same cycle.
          if (remaining_q == 8'd1) begin
            if (&rom_addr_q && !loop) begin
              state_d = S_DONE;
            end else begin
              rom_addr_d = rom_addr_q + 1'b1;
              state_d    = S_FETCH;
            end
          end
        end else begin
          prescaler_d = prescaler_q + 1'b1;
        end
      end
      S_PAUSE: if (play) state_d = S_PLAY;
      S_DONE:  if (!play) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_PLAY: begin
        if (GAP_EN && cur_note_d != 8'd0 && dur_d > GAP_L && remaining_d <= GAP_L)
          note_d = 8'd0;
        else
          note_d = cur_note_d;
      end
      S_FETCH, S_LATCH: note_d = note_q;
      default:          note_d = 8'd0;
    endcase
  end

  assign rom_addr    = rom_addr_q;
  assign note        = note_q;
  assign note_strobe = note_strobe_q;
  assign busy        = (state_q == S_FETCH) || (state_q == S_LATCH) ||
                       (state_q == S_PLAY)  || (state_q == S_PAUSE);
  assign done        = (state_q == S_DONE);

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Upstream stage of the music box tone generator. It replaces free-running address bits with a tempo-driven song player.
- Reads (note, duration) words from a synchronous song ROM and holds each note for its programmed number of tempo ticks.
- Presents a registered 8-bit note code to the octave/note divider stage. Code 0 means rest.
- Supports play/pause, looping, tempo scaling and an end-of-song marker.

Parameters:
- TICK_DIV, 1562500: CLK100MHZ cycles per tempo tick at tempo_sel=0 (64 ticks/s).
- ADDR_W, 8: ROM address width.
- GAP_TICKS, 1: articulation rest ticks at the end of each note (optional feature only).

Ports:
- CLK100MHZ  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- play  input  1  level; 1 = run, 0 = pause/stop.
- loop  input  1  level; 1 = restart at address 0 on end marker.
- tempo_sel  input  2  tick period = TICK_DIV >> tempo_sel (x1, x2, x4, x8 speed).
- rom_addr  output  ADDR_W  ROM address, registered.
- rom_data  input  16  [15:8] note code, [7:0] duration in ticks; valid one cycle after rom_addr.
- note  output  8  current note code to the divider stage, registered.
- note_strobe  output  1  one-cycle pulse when note loads a new ROM entry.
- busy  output  1  high in FETCH/LATCH/PLAY/PAUSE.
- done  output  1  high in DONE.

Behaviour:
- Reset: state IDLE. rom_addr=0, note=0, note_strobe=0, busy=0, done=0, prescaler=0, remaining=0. Reset mid-song aborts immediately, with no drain.

State machine:
- IDLE: note=0. If play=1 → FETCH with rom_addr=0.
- FETCH: one-cycle wait for ROM latency → LATCH.
- LATCH, end marker (rom_data[7:0]==0):
  - if loop=1: rom_addr<=0 → FETCH;
  - else → DONE, note<=0.
- LATCH, any other duration:
  - note<=rom_data[15:8], remaining<=rom_data[7:0], note_strobe<=1 for one cycle, prescaler<=0 → PLAY.
- PLAY:
  - Prescaler counts 0..(TICK_DIV>>tempo_sel)-1. On wrap, a tick fires and remaining decrements.
  - When a tick takes remaining 1→0: rom_addr<=rom_addr+1 → FETCH.
  - If rom_addr is all-ones at that point, the increment is an end of song and follows the LATCH end-marker rules (loop → address 0, else DONE).
  - If play=0 → PAUSE.
- PAUSE: note output forced to 0, while the latched note, remaining and prescaler are frozen. play=1 → PLAY, with note restored the next cycle.
- DONE: note=0, done=1. play=0 → IDLE, so a new rising play restarts from address 0.

Timing and width rules:
- Startup latency: play sampled high in IDLE → note valid 3 clock edges later.
- Inter-note overhead is 2 cycles (FETCH, LATCH); note holds the previous value during them.
- Note with duration D at tempo_sel=s lasts D*(TICK_DIV>>s) + 2 cycles.
- tempo_sel is sampled continuously; a change takes effect at the next prescaler wrap.
- The prescaler compare uses the new value without underflow: if the prescaler ≥ new period, it wraps next cycle.
- The note code is passed unmodified. The downstream stage uses bits [5:0] only, but all 8 bits are registered.
- Simultaneous events: rst dominates everything. In PLAY, play=0 on the same cycle as the last tick → the address advance completes first, then the next state is PAUSE after LATCH loads the new note, with the output forced to 0.

Optional Feature:
- SEQ_GAP_EN defined:
  - For notes with nonzero code and duration > GAP_TICKS, note is driven 0 while remaining ≤ GAP_TICKS, giving repeated notes audible separation.
  - note_strobe is unaffected.
- SEQ_GAP_EN undefined: legato. The note is held for its full duration and GAP_TICKS is ignored.

Test Plan:
- Basic play (TICK_DIV=10, tempo_sel=0): ROM {0x1D03, 0x2202, 0x0000}, loop=0, play=1 → note=0x1D 3 edges later for 30 cycles, then 0x22 for 20 cycles (after 2 overhead cycles), then done=1 and note=0.
- Loop: same ROM, loop=1 → after 0x22 ends, note returns to 0x1D. note_strobe pulses exactly once per entry and done never asserts.
- Pause/resume: play=0 for 50 cycles mid-way (15 cycles into 0x1D03) → note=0 throughout, remaining frozen. After play=1, 0x1D lasts exactly 15 more cycles.
- Tempo: tempo_sel=2, TICK_DIV=40, entry 0x2904 → note held 40 cycles. Switching to tempo_sel=0 mid-note lengthens the remaining ticks to 40 cycles each.
- SEQ_GAP_EN, GAP_TICKS=1: entries 0x1D03, 0x1D03 → pattern of 20 cycles 0x1D, then 10 cycles 0, then 2 overhead cycles, repeated. Without the macro, 0x1D is continuous.
- Reset mid-note: rst=1 for one cycle during PLAY → next cycle note=0, rom_addr=0, busy=0. With play still high, a restart from address 0 occurs with note valid 3 edges after rst drops.
